// File: rtl/taillight_pkg.sv
// Shared types and lamp patterns for the Thunderbird tail-light cluster.
// Lamp vectors are ordered {lc, lb, la, ra, rb, rc}.
package taillight_pkg;

    typedef enum logic [2:0] {
        IDLE,
        L1,
        L2,
        L3,
        R1,
        R2,
        R3,
        HAZ
    } state_t;

    typedef enum logic {
        LEFT,
        RIGHT
    } side_t;

    localparam logic [5:0] LAMP_OFF   = 6'b000_000;
    localparam logic [5:0] LAMP_L1    = 6'b001_000;
    localparam logic [5:0] LAMP_L2    = 6'b011_000;
    localparam logic [5:0] LAMP_L3    = 6'b111_000;
    localparam logic [5:0] LAMP_R1    = 6'b000_100;
    localparam logic [5:0] LAMP_R2    = 6'b000_110;
    localparam logic [5:0] LAMP_R3    = 6'b000_111;
    localparam logic [5:0] LAMP_ALL   = 6'b111_111;
    localparam logic [5:0] LAMP_LSIDE = 6'b111_000;
    localparam logic [5:0] LAMP_RSIDE = 6'b000_111;

    function automatic logic [5:0] base_lamps(input state_t s);
        logic [5:0] v;
        v = LAMP_OFF;
        unique case (s)
            IDLE:    v = LAMP_OFF;
            L1:      v = LAMP_L1;
            L2:      v = LAMP_L2;
            L3:      v = LAMP_L3;
            R1:      v = LAMP_R1;
            R2:      v = LAMP_R2;
            R3:      v = LAMP_R3;
            HAZ:     v = LAMP_ALL;
            default: v = LAMP_OFF;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/taillight_arbiter_tick_divider.sv
// Animation prescaler: tick pulses once every TICK_DIV clk cycles.
// With TICK_DIV=1 the counter stays at 0 and tick is always high.
module tick_divider #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    assign tick   = w_last;

    // Count 0..TICK_DIV-1 and wrap; reset takes priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/taillight_arbiter.sv
// Tail-light sequencer: arbitrates left/right/hazard on each tick.
// Optional brake overlay is enabled by defining TAILLIGHT_BRAKE_EN.
module taillight_arbiter
    import taillight_pkg::*;
#(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic left,
    input  logic right,
    input  logic hazard,
`ifdef TAILLIGHT_BRAKE_EN
    input  logic brake,
`endif
    output logic lc,
    output logic lb,
    output logic la,
    output logic ra,
    output logic rb,
    output logic rc,
    output logic busy
);

    state_t     r_state;
    state_t     w_next;
    side_t      r_last_side;
    side_t      w_next_side;
    logic       w_tick;
    logic [5:0] w_lamps;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    // State and round-robin flag only move on a tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_last_side <= RIGHT;
        end else begin
            r_state     <= w_next;
            r_last_side <= w_next_side;
        end
    end

    // Next state: requests are only looked at from IDLE.
    always_comb begin
        w_next      = r_state;
        w_next_side = r_last_side;
        if (w_tick) begin
            unique case (r_state)
                IDLE: begin
                    if (hazard) begin
                        w_next = HAZ;
                    end else if (left && right) begin
                        if (r_last_side == RIGHT) begin
                            w_next      = L1;
                            w_next_side = LEFT;
                        end else begin
                            w_next      = R1;
                            w_next_side = RIGHT;
                        end
                    end else if (left) begin
                        w_next      = L1;
                        w_next_side = LEFT;
                    end else if (right) begin
                        w_next      = R1;
                        w_next_side = RIGHT;
                    end
                end
                L1:      w_next = L2;
                L2:      w_next = L3;
                L3:      w_next = IDLE;
                R1:      w_next = R2;
                R2:      w_next = R3;
                R3:      w_next = IDLE;
                HAZ:     w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

`ifdef TAILLIGHT_BRAKE_EN
    // Brake lights every lamp not already used for signalling.
    always_comb begin
        w_lamps = base_lamps(r_state);
        if (brake) begin
            unique case (r_state)
                L1, L2, L3: w_lamps = w_lamps | LAMP_RSIDE;
                R1, R2, R3: w_lamps = w_lamps | LAMP_LSIDE;
                default:    w_lamps = LAMP_ALL;
            endcase
        end
    end
`else
    // Lamps are a pure decode of the registered state.
    always_comb begin
        w_lamps = base_lamps(r_state);
    end
`endif

    assign {lc, lb, la, ra, rb, rc} = w_lamps;
    assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_taillight_arbiter.sv
// Self-checking bench: two instances (TICK_DIV 4 and 1) share stimulus
// and are compared every cycle against a step/side reference model.
module tb_taillight_arbiter;

    logic clk = 1'b0;
    logic reset, left, right, hazard, brake;
    logic lc0, lb0, la0, ra0, rb0, rc0, busy0;
    logic lc1, lb1, la1, ra1, rb1, rc1, busy1;

    int checks = 0;
    int fails  = 0;
    int cyc_n  = 0;

    // model: mode 0 idle, 1 left, 2 right, 3 hazard; step 1..3
    int m_div  [2] = '{4, 1};
    int m_cnt  [2];
    int m_mode [2];
    int m_step [2];
    int m_last [2];   // 0 left, 1 right

`ifdef TAILLIGHT_BRAKE_EN
    localparam bit BRAKE_ON = 1'b1;
`else
    localparam bit BRAKE_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    taillight_arbiter #(.TICK_DIV(4)) dut0 (
        .clk(clk), .reset(reset), .left(left), .right(right),
        .hazard(hazard),
`ifdef TAILLIGHT_BRAKE_EN
        .brake(brake),
`endif
        .lc(lc0), .lb(lb0), .la(la0), .ra(ra0), .rb(rb0), .rc(rc0),
        .busy(busy0)
    );

    taillight_arbiter #(.TICK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .left(left), .right(right),
        .hazard(hazard),
`ifdef TAILLIGHT_BRAKE_EN
        .brake(brake),
`endif
        .lc(lc1), .lb(lb1), .la(la1), .ra(ra1), .rb(rb1), .rc(rc1),
        .busy(busy1)
    );

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     tag, cyc_n, obs, exp);
        end
    endtask

    task automatic model_edge(input int k);
        int side;
        if (reset) begin
            m_cnt[k]  = 0;
            m_mode[k] = 0;
            m_step[k] = 0;
            m_last[k] = 1;
        end else begin
            if (m_cnt[k] == m_div[k] - 1) begin
                if (m_mode[k] != 0) begin
                    if (m_mode[k] == 3 || m_step[k] == 3) begin
                        m_mode[k] = 0;
                        m_step[k] = 0;
                    end else begin
                        m_step[k]++;
                    end
                end else if (hazard) begin
                    m_mode[k] = 3;
                    m_step[k] = 1;
                end else if (left || right) begin
                    if (left && right) side = 1 - m_last[k];
                    else               side = left ? 0 : 1;
                    m_mode[k] = side + 1;
                    m_step[k] = 1;
                    m_last[k] = side;
                end
            end
            m_cnt[k] = (m_cnt[k] + 1) % m_div[k];
        end
    endtask

    function automatic logic [5:0] exp_lamps(input int k);
        int ll, rl;
        logic [5:0] v;
        ll = (m_mode[k] == 1) ? m_step[k] : (m_mode[k] == 3) ? 3 : 0;
        rl = (m_mode[k] == 2) ? m_step[k] : (m_mode[k] == 3) ? 3 : 0;
        v = {ll >= 3, ll >= 2, ll >= 1, rl >= 1, rl >= 2, rl >= 3};
        if (BRAKE_ON && brake) begin
            if (m_mode[k] == 1)      v = v | 6'b000111;
            else if (m_mode[k] == 2) v = v | 6'b111000;
            else                     v = 6'b111111;
        end
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        cyc_n++;
        check("lamps_div4", {2'b0, lc0, lb0, la0, ra0, rb0, rc0},
              {2'b0, exp_lamps(0)});
        check("busy_div4", {7'b0, busy0}, {7'b0, m_mode[0] != 0});
        check("lamps_div1", {2'b0, lc1, lb1, la1, ra1, rb1, rc1},
              {2'b0, exp_lamps(1)});
        check("busy_div1", {7'b0, busy1}, {7'b0, m_mode[1] != 0});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        bit seen;
        reset = 1'b1; left = 1'b0; right = 1'b0;
        hazard = 1'b0; brake = 1'b0;
        cyc();
        cyc();

        // left held from reset: la rises 4 cycles after release
        left = 1'b1;
        do_reset();
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc();
            n++;
            if (la0) seen = 1'b1;
        end
        check("la_latency", 8'(n), 8'd4);
        repeat (36) cyc();

        // left and right held: round-robin
        right = 1'b1;
        do_reset();
        repeat (48) cyc();
        left = 1'b0; right = 1'b0;

        // right held, hazard raised during R2
        right = 1'b1;
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cyc();
            if (m_mode[0] == 2 && m_step[0] == 2) seen = 1'b1;
        end
        check("reach_r2", {7'b0, seen}, 8'd1);
        hazard = 1'b1;
        repeat (40) cyc();
        hazard = 1'b0; right = 1'b0;

        // 2-cycle left pulse while cnt = 0..1
        do_reset();
        left = 1'b1;
        cyc();
        cyc();
        left = 1'b0;
        repeat (8) cyc();

        // reset mid-L2 on the TICK_DIV=1 instance
        left = 1'b1;
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cyc();
            if (m_mode[1] == 1 && m_step[1] == 2) seen = 1'b1;
        end
        check("reach_l2", {7'b0, seen}, 8'd1);
        reset = 1'b1;
        cyc();
        check("rst_off", {2'b0, lc1, lb1, la1, ra1, rb1, rc1}, 8'h00);
        reset = 1'b0;
        cyc();
        check("rst_l1", {2'b0, lc1, lb1, la1, ra1, rb1, rc1}, 8'h08);
        left = 1'b0;

        // brake overlay (no effect when the port is absent)
        do_reset();
        brake = 1'b1;
        repeat (3) cyc();
        left = 1'b1;
        repeat (12) cyc();
        brake = 1'b0;
        repeat (6) cyc();
        left = 1'b0;

        // random traffic
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            reset  = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) left  = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) right = $urandom_range(0, 1);
            if ($urandom_range(0, 15) == 0) hazard = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) brake = $urandom_range(0, 1);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/taillight_arbiter.md
# taillight_arbiter

Sequencing controller for the six-lamp Thunderbird tail-light cluster. Arbitrates left-turn, right-turn and hazard requests from the steering-column switches and paces the animation from an internal prescaler. Drives LA/LB/LC and RA/RB/RC directly, so the lamps never change faster than one step per tick. Left and right held together are served round-robin instead of left always winning.

## Interface
- TICK_DIV, 4: clk cycles per animation step; legal range ≥1.
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- left  in  1  left-turn request, level.
- right  in  1  right-turn request, level.
- hazard  in  1  hazard request, level.
- brake  in  1  brake pedal, level; present only with TAILLIGHT_BRAKE_EN.
- lc, lb, la  out  1 each  left lamps, outer to inner is lc..la.
- ra, rb, rc  out  1 each  right lamps, inner to outer is ra..rc.
- busy  out  1  high while state ≠ IDLE.

## Operation
- Prescaler cnt counts 0..TICK_DIV-1 and wraps.
  - tick is high when cnt == TICK_DIV-1.
  - With TICK_DIV=1, tick is high every cycle.
- States and their base lamps (Moore, decoded from state):
  - IDLE: all off.
  - L1: la.
  - L2: la, lb.
  - L3: la, lb, lc.
  - R1: ra.
  - R2: ra, rb.
  - R3: ra, rb, rc.
  - HAZ: all six on.
- State changes only on a tick edge. Without a tick, the state holds.
- Transitions on tick:
  - L1→L2→L3→IDLE.
  - R1→R2→R3→IDLE.
  - HAZ→IDLE.
  - From IDLE, by priority: hazard→HAZ. Else left&right→the side opposite last_side. Else left→L1. Else right→R1. Else stay in IDLE.
- last_side is a flag updated on entry to L1 (=LEFT) or R1 (=RIGHT).
  - Reset value RIGHT, so the first simultaneous request serves left.
  - HAZ does not change last_side.
- Requests are sampled only in IDLE on a tick.
  - Once started, a sequence always completes, even if the request is released or hazard asserts mid-sequence.
  - A pending hazard is served on the IDLE tick that follows the sequence.
- Held hazard alternates HAZ/IDLE: one step on, one step off.
- Held left gives a repeating cycle L1, L2, L3, IDLE, L1, … with period 4 ticks.

## Timing
- Reset (synchronous, dominant over tick) forces:
  - state = IDLE, cnt = 0, last_side = RIGHT.
  - All lamps and busy = 0.
- cnt = 0 in the first cycle after reset deasserts; the first tick is TICK_DIV-1 cycles later.
- Request-to-lamp latency:
  - Lamps change on the clock edge at which tick is high.
  - Worst case from request assertion to la/ra is TICK_DIV cycles; best case is 1 cycle.
- A request must be high during the tick cycle to be seen. Pulses between ticks are ignored; nothing is latched.
- Outputs are combinational from registered state (and from brake if enabled). They have no added latency and no glitches on the request inputs.
- Reset asserted mid-sequence: lamps are 0 on the following cycle. No sequence is resumed afterwards.

## Configuration
- Macro: TAILLIGHT_BRAKE_EN.
- When defined, the brake port exists and lamps are the base lamps OR'd with brake lamps:
  - IDLE: all six on.
  - L1–L3: all right lamps on.
  - R1–R3: all left lamps on.
  - HAZ: all six on.
- brake has no effect on state, arbitration, last_side or busy.
- When undefined, there is no brake port and lamps are the base lamps only.

## Structure
- Package taillight_pkg holds:
  - State enum: IDLE, L1, L2, L3, R1, R2, R3, HAZ.
  - 6-bit lamp-pattern constants per state, bit order {lc, lb, la, ra, rb, rc}.
  - Side enum: LEFT, RIGHT.
- Sub-module tick_divider:
  - Parameter TICK_DIV; ports clk, reset, tick.
  - Counter width $clog2(TICK_DIV), minimum 1.
- The top contains the arbiter FSM, last_side and lamp decode.

## Test plan
- Reset, then left held, TICK_DIV=4: la rises 4 cycles after reset deasserts. Then {la}, {la,lb}, {la,lb,lc}, off, each lasting 4 cycles, repeating. Right lamps stay 0 and busy is 0 only during IDLE.
- left and right both held from reset: sequences alternate L, R, L, R. last_side toggles on each IDLE exit.
- right held; hazard asserted during R2: R2, R3 and IDLE complete, then HAZ. Held hazard then gives all-on/all-off steps of 4 cycles each.
- left pulsed for 2 cycles between ticks (cnt = 0..1): no state change, lamps stay 0.
- Reset asserted in L2 with TICK_DIV=1: all lamps are 0 the next cycle. After release with left held, L1 appears on the next cycle.
- TAILLIGHT_BRAKE_EN with brake high:
  - IDLE: all six lamps on.
  - During L2: la, lb, ra, rb, rc on, lc off.
  - Releasing brake restores the base pattern the same cycle.
